// File: rtl/lsu_bus_pkg.sv
// Shared definitions for the LSU bus: default widths, master indices and the I/O map.
package lsu_bus_pkg;

    localparam int unsigned LSU_AW = 32;
    localparam int unsigned LSU_DW = 32;

    typedef enum logic {
        M_CPU = 1'b0,
        M_DBG = 1'b1
    } mst_idx_e;

    localparam logic [31:0] ADDR_HEX0 = 32'h0000_0800;
    localparam logic [31:0] ADDR_HEX1 = 32'h0000_0810;
    localparam logic [31:0] ADDR_HEX2 = 32'h0000_0820;
    localparam logic [31:0] ADDR_HEX3 = 32'h0000_0830;
    localparam logic [31:0] ADDR_HEX4 = 32'h0000_0840;
    localparam logic [31:0] ADDR_HEX5 = 32'h0000_0850;
    localparam logic [31:0] ADDR_HEX6 = 32'h0000_0860;
    localparam logic [31:0] ADDR_HEX7 = 32'h0000_0870;
    localparam logic [31:0] ADDR_LEDR = 32'h0000_0880;
    localparam logic [31:0] ADDR_LEDG = 32'h0000_0890;
    localparam logic [31:0] ADDR_LCD  = 32'h0000_08A0;
    localparam logic [31:0] ADDR_SW   = 32'h0000_0900;

    // Seven-segment displays sit on a 16-byte stride starting at HEX0.
    function automatic logic [31:0] hex_addr(input int unsigned idx);
        return ADDR_HEX0 + 32'(idx << 4);
    endfunction

endpackage

// File: rtl/lsu_rr_arb2.sv
// Combinational two-way round-robin pick with lock retention and a forced handover
// once the locked owner has used up its hold budget.
module lsu_rr_arb2
    import lsu_bus_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic [1:0] i_lock,
    input  mst_idx_e   i_last,
    input  logic       i_lock_q,
    input  mst_idx_e   i_owner,
    input  logic       i_hold_max,
    output logic [1:0] o_gnt,
    output mst_idx_e   o_idx
);

    mst_idx_e w_other;
    logic     w_owner_req;
    logic     w_owner_lock;
    logic     w_other_req;
    logic     w_locked;
    logic     w_forced;

    assign w_other      = (i_owner == M_CPU) ? M_DBG : M_CPU;
    assign w_owner_req  = (i_owner == M_DBG) ? i_req[1] : i_req[0];
    assign w_owner_lock = (i_owner == M_DBG) ? i_lock[1] : i_lock[0];
    assign w_other_req  = (i_owner == M_DBG) ? i_req[0] : i_req[1];
    assign w_locked     = i_lock_q & w_owner_req & w_owner_lock;
    assign w_forced     = w_locked & i_hold_max & w_other_req;

    always_comb begin
        o_idx = M_CPU;
        if (w_forced) begin
            o_idx = w_other;
        end else if (w_locked) begin
            o_idx = i_owner;
        end else if (i_req == 2'b11) begin
            o_idx = (i_last == M_CPU) ? M_DBG : M_CPU;
        end else if (i_req[1]) begin
            o_idx = M_DBG;
        end
    end

    always_comb begin
        o_gnt = 2'b00;
        if (|i_req) begin
            o_gnt = (o_idx == M_DBG) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Shares the single LSU port between the CPU data port (m0) and the debug/DMA port (m1),
// routing the one-cycle-late load data back to whichever master issued the read.
module lsu_arbiter
    import lsu_bus_pkg::*;
#(
    parameter int unsigned AW       = LSU_AW,
    parameter int unsigned DW       = LSU_DW,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          m0_req_i,
    input  logic          m0_lock_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdata_i,
    output logic          m0_gnt_o,
    output logic          m0_rvalid_o,
    output logic [DW-1:0] m0_rdata_o,
    input  logic          m1_req_i,
    input  logic          m1_lock_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdata_i,
    output logic          m1_gnt_o,
    output logic          m1_rvalid_o,
    output logic [DW-1:0] m1_rdata_o,
    output logic [AW-1:0] lsu_addr_o,
    output logic [DW-1:0] lsu_st_data_o,
    output logic          lsu_st_en_o,
    input  logic [DW-1:0] lsu_ld_data_i
);

    localparam int unsigned HW = 8;

    logic [1:0]    w_req;
    logic [1:0]    w_lock_in;
    logic [1:0]    w_gnt;
    mst_idx_e      w_idx;
    logic          w_accept;
    logic          w_hold_max;
    logic          w_sel_we;
    logic          w_sel_lock;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    mst_idx_e      r_last, w_last_d;
    logic          r_lock, w_lock_d;
    mst_idx_e      r_owner, w_owner_d;
    logic [HW-1:0] r_hold_cnt, w_hold_d;
    logic          r_rd_pend, w_rd_pend_d;
    mst_idx_e      r_rd_id, w_rd_id_d;

    // Requests are masked in reset so no grant or LSU strobe escapes while rst_ni is low.
    assign w_req      = {m1_req_i, m0_req_i} & {2{rst_ni}};
    assign w_lock_in  = {m1_lock_i, m0_lock_i};
    assign w_hold_max = (r_hold_cnt == HW'(MAX_HOLD));

    lsu_rr_arb2 u_arb (
        .i_req      (w_req),
        .i_lock     (w_lock_in),
        .i_last     (r_last),
        .i_lock_q   (r_lock),
        .i_owner    (r_owner),
        .i_hold_max (w_hold_max),
        .o_gnt      (w_gnt),
        .o_idx      (w_idx)
    );

    assign w_accept = |w_gnt;
    assign m0_gnt_o = w_gnt[0];
    assign m1_gnt_o = w_gnt[1];

    always_comb begin
        if (w_idx == M_DBG) begin
            w_sel_we    = m1_we_i;
            w_sel_lock  = m1_lock_i;
            w_sel_addr  = m1_addr_i;
            w_sel_wdata = m1_wdata_i;
        end else begin
            w_sel_we    = m0_we_i;
            w_sel_lock  = m0_lock_i;
            w_sel_addr  = m0_addr_i;
            w_sel_wdata = m0_wdata_i;
        end
    end

    assign lsu_addr_o    = w_accept ? w_sel_addr : '0;
    assign lsu_st_data_o = w_accept ? w_sel_wdata : '0;
    assign lsu_st_en_o   = w_accept & w_sel_we;

    always_comb begin
        w_last_d    = r_last;
        w_owner_d   = r_owner;
        w_hold_d    = r_hold_cnt;
        w_lock_d    = w_accept & w_sel_lock;
        w_rd_pend_d = w_accept & ~w_sel_we;
        w_rd_id_d   = w_idx;
        if (w_accept) begin
            w_last_d  = w_idx;
            w_owner_d = w_idx;
            if (w_idx != r_last) begin
                w_hold_d = HW'(1);
            end else if (r_hold_cnt < HW'(MAX_HOLD)) begin
                w_hold_d = r_hold_cnt + HW'(1);
            end
        end else if (!r_lock) begin
            w_hold_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last     <= M_DBG;
            r_owner    <= M_CPU;
            r_lock     <= 1'b0;
            r_hold_cnt <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_id    <= M_CPU;
        end else begin
            r_last     <= w_last_d;
            r_owner    <= w_owner_d;
            r_lock     <= w_lock_d;
            r_hold_cnt <= w_hold_d;
            r_rd_pend  <= w_rd_pend_d;
            r_rd_id    <= w_rd_id_d;
        end
    end

    assign m0_rvalid_o = r_rd_pend & (r_rd_id == M_CPU);
    assign m1_rvalid_o = r_rd_pend & (r_rd_id == M_DBG);
    assign m0_rdata_o  = m0_rvalid_o ? lsu_ld_data_i : '0;
    assign m1_rdata_o  = m1_rvalid_o ? lsu_ld_data_i : '0;

endmodule

// File: doc/lsu_arbiter.md
Name: lsu_arbiter

Overview:
- Two-master arbiter that shares the single memory-mapped I/O load/store unit (LSU) port between requesters.
- Master 0 is the CPU data port. Master 1 is the debug/DMA port.
- Sits between the masters and the LSU. Drives the LSU addr/st_data/st_en and returns the LSU's registered ld_data to the master that issued the read.
- Round-robin arbitration, optional bus lock, and a hold limit that bounds starvation.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_HOLD, 8, max consecutive grants to a locked master while the other master is waiting (range 1..255).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- m0_req_i  in  1  master 0 request.
- m0_lock_i  in  1  master 0 asks to keep ownership after this access.
- m0_we_i  in  1  master 0 write (1) / read (0).
- m0_addr_i  in  AW  master 0 address.
- m0_wdata_i  in  DW  master 0 store data.
- m0_gnt_o  out  1  master 0 granted this cycle.
- m0_rvalid_o  out  1  master 0 read data valid.
- m0_rdata_o  out  DW  master 0 read data.
- m1_*  same seven ports as m0_*, for master 1.
- lsu_addr_o  out  AW  to LSU addr.
- lsu_st_data_o  out  DW  to LSU st_data.
- lsu_st_en_o  out  1  to LSU st_en.
- lsu_ld_data_i  in  DW  from LSU ld_data. Registered in the LSU: valid one cycle after the address is presented with st_en=0.

Behaviour:
- Grant logic
  - gnt is combinational from req and registered state. A master is never granted without req. At most one gnt per cycle.
  - Accept = req & gnt. The master holds req/we/addr/wdata stable until accepted.
- Arbitration priority, per cycle:
  - (1) Locked owner keeps the grant while its req and lock are high, unless hold_cnt == MAX_HOLD and the other master requests.
  - (2) Otherwise, a single requester wins.
  - (3) When both request, the master not granted most recently (last_q) wins.
- Registered state
  - last_q: index of the last accepted master.
  - lock_q / owner_q: lock_q <= accept & granted lock_i. It clears when the owner drops req or lock, or loses the grant to a forced handover.
  - hold_cnt: increments on each accept by the same master as the previous accept and saturates at MAX_HOLD. Resets to 1 on a grant switch, and to 0 when idle with no lock.
- LSU drive
  - On accept: lsu_addr_o/lsu_st_data_o come from the granted master, and lsu_st_en_o = granted we.
  - With no accept: lsu_addr_o=0, lsu_st_data_o=0, lsu_st_en_o=0.
- Read return
  - rd_pend_q / rd_id_q are set on an accepted read.
  - The next cycle: m{rd_id}_rvalid_o=1 and m{rd_id}_rdata_o=lsu_ld_data_i. All other rdata outputs are 0.
  - Latency is exactly 1 cycle. Back-to-back reads return on consecutive cycles in issue order.
  - Writes produce no response.
  - A new accept in the rvalid cycle is allowed; no bubble is required.
- Reset (rst_ni low, async)
  - Outputs: all gnt=0, rvalid=0, rdata=0, LSU outputs 0.
  - State: last_q=1 (master 0 wins the first tie), lock_q=0, hold_cnt=0, rd_pend_q=0.
  - Reset mid-read drops the pending rvalid.
- Boundary cases
  - A master dropping req in the cycle its lock would hold releases ownership immediately; the other master may be granted in that same cycle.
  - Lock asserted by a master that loses the forced handover is ignored until it next wins arbitration.
  - MAX_HOLD=1 degenerates to strict alternation under contention.

Decomposition:
- Package lsu_bus_pkg:
  - AW/DW defaults.
  - Master index type (M_CPU=0, M_DBG=1).
  - I/O map constants: HEX0..HEX7 at 0x800..0x870 (step 0x10), LEDR 0x880, LEDG 0x890, LCD 0x8A0, SW 0x900.
- Sub-module lsu_rr_arb2: combinational 2-way pick from req[1:0], last_q, lock/owner and hold_cnt==MAX_HOLD. Outputs the grant vector and the granted index.
- Top-level lsu_arbiter holds the registers and the mux/response logic.

Test Plan:
1. Reset release, m0 read 0x900 with io_sw=0x5A: m0_gnt_o=1 same cycle, lsu_addr_o=0x900, lsu_st_en_o=0; next cycle m0_rvalid_o=1, m0_rdata_o=0x0000005A, m1_rvalid_o=0.
2. Both request in the same cycle (m0 write 0x800 data 0x11, m1 write 0x810 data 0x22), no lock: grants alternate m0, m1. io_hex0=0x11, io_hex1=0x22.
3. m0 locked with req held, m1 requesting, MAX_HOLD=4: m0 granted 4 consecutive cycles, m1 granted on the 5th, then round-robin resumes.
4. Interleaved reads: m1 read 0x900 in cycle N, m0 read 0x900 in cycle N+1, io_sw changes 0x1→0x2 between them: m1_rvalid in N+1 with 0x1, m0_rvalid in N+2 with 0x2.
5. rst_ni asserted in the cycle after an accepted read: rvalid never asserted, all outputs 0. After release, the first tie goes to m0.
6. Write to the unmapped address 0x8B0 by m1: gnt asserted, lsu_st_en_o=1, no LSU register changes, no rvalid.
